// File: rtl/snell_sequencer_if.sv
// Operand and result handshake bundle between the Snell sequencer and its environment.
// The environment (master) supplies operands and consumes results; the sequencer is the slave.
interface snell_sequencer_if;
    logic       in_valid;
    logic [6:0] in_data;
    logic       in_ready;
    logic       res_valid;
    logic [3:0] res_data;
    logic       res_err;
    logic       res_ready;

    modport master (
        output in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  in_valid, in_data, res_ready,
        output in_ready, res_valid, res_data, res_err
    );
endinterface

// File: rtl/snell_sequencer.sv
// Control sequencer for the Snell's-law datapath: loads n2/theta1/theta2, waits out the
// datapath latency, captures n1 and holds it until the consumer takes it.
module snell_sequencer #(
    parameter int LAT = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    snell_sequencer_if.slave bus,
    output logic [6:0]       dp_data,
    output logic             n2_sel,
    output logic             t1_sel,
    output logic             t2_sel,
    output logic             out_sel,
    input  logic [6:0]       dp_result,
    output logic             busy
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LD_N2 = 3'd1;
    localparam logic [2:0] LD_T1 = 3'd2;
    localparam logic [2:0] LD_T2 = 3'd3;
    localparam logic [2:0] WAIT  = 3'd4;
    localparam logic [2:0] READ  = 3'd5;
    localparam logic [2:0] CAPT  = 3'd6;
    localparam logic [2:0] HOLD  = 3'd7;

    localparam logic [7:0] CNT_INIT = 8'(LAT - 1);

    logic [2:0] state;
    logic [7:0] cnt;
    logic       err;
    logic       capt_wait;
    logic       accept;

    // Only n1 (low nibble) is consumed from the datapath output.
    logic unused_dp_hi;
    assign unused_dp_hi = ^dp_result[6:4];

    assign bus.in_ready = (state == LD_N2) || (state == LD_T1) || (state == LD_T2);
    assign accept       = bus.in_valid && bus.in_ready;
    assign busy         = (state != IDLE);

    // NOTE: all state lives in this one block with non-blocking assignments, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            err           <= 1'b0;
            capt_wait     <= 1'b0;
            dp_data       <= '0;
            n2_sel        <= 1'b0;
            t1_sel        <= 1'b0;
            t2_sel        <= 1'b0;
            out_sel       <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_err   <= 1'b0;
        end else begin
            // Strobes are single-cycle: low unless a branch below raises one.
            n2_sel  <= 1'b0;
            t1_sel  <= 1'b0;
            t2_sel  <= 1'b0;
            out_sel <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    err   <= 1'b0;
                    state <= LD_N2;
                end
                LD_N2: if (accept) begin
                    dp_data <= bus.in_data;
                    n2_sel  <= 1'b1;
                    err     <= err || (bus.in_data[3:0] == 4'd0);
                    state   <= LD_T1;
                end
                LD_T1: if (accept) begin
                    dp_data <= bus.in_data;
                    t1_sel  <= 1'b1;
                    err     <= err || (bus.in_data == 7'd0) || (bus.in_data > 7'd90);
                    state   <= LD_T2;
                end
                LD_T2: if (accept) begin
                    dp_data <= bus.in_data;
                    t2_sel  <= 1'b1;
                    if (err || (bus.in_data > 7'd90)) begin
                        // Out-of-range operand: report immediately, datapath result is meaningless.
                        err           <= 1'b1;
                        bus.res_valid <= 1'b1;
                        bus.res_data  <= '0;
                        bus.res_err   <= 1'b1;
                        state         <= HOLD;
                    end else begin
                        cnt   <= CNT_INIT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 8'd0) begin
                        out_sel <= 1'b1;
                        state   <= READ;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                READ: begin
                    capt_wait <= 1'b1;
                    state     <= CAPT;
                end
                CAPT: begin
                    // First CAPT cycle lets the datapath output register load after out_sel.
                    if (capt_wait) begin
                        capt_wait <= 1'b0;
                    end else begin
                        bus.res_data  <= dp_result[3:0];
                        bus.res_err   <= 1'b0;
                        bus.res_valid <= 1'b1;
                        state         <= HOLD;
                    end
                end
                HOLD: if (bus.res_ready) begin
                    bus.res_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snell_sequencer.sv
// Self-checking bench: two sequencers (LAT=24 and LAT=2) against a transaction-level model
// and a datapath stub, with directed transactions and hand-computed result literals.
module tb_snell_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [6:0] in_data;
    logic       res_ready;
    logic       start_v [2];

    always #5 clk = ~clk;

    snell_sequencer_if bus_a ();
    snell_sequencer_if bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_data   = in_data;
    assign bus_a.res_ready = res_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_data   = in_data;
    assign bus_b.res_ready = res_ready;

    logic [6:0] dp_data [2];
    logic [6:0] dp_res  [2];
    logic       n2s [2];
    logic       t1s [2];
    logic       t2s [2];
    logic       os  [2];
    logic       busy_v [2];
    logic       rdy [2];
    logic       rv  [2];
    logic [3:0] rd  [2];
    logic       re  [2];

    assign rdy[0] = bus_a.in_ready;
    assign rv[0]  = bus_a.res_valid;
    assign rd[0]  = bus_a.res_data;
    assign re[0]  = bus_a.res_err;
    assign rdy[1] = bus_b.in_ready;
    assign rv[1]  = bus_b.res_valid;
    assign rd[1]  = bus_b.res_data;
    assign re[1]  = bus_b.res_err;

    snell_sequencer #(.LAT(24)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .bus(bus_a.slave),
        .dp_data(dp_data[0]), .n2_sel(n2s[0]), .t1_sel(t1s[0]), .t2_sel(t2s[0]),
        .out_sel(os[0]), .dp_result(dp_res[0]), .busy(busy_v[0])
    );

    snell_sequencer #(.LAT(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .bus(bus_b.slave),
        .dp_data(dp_data[1]), .n2_sel(n2s[1]), .t1_sel(t1s[1]), .t2_sel(t2s[1]),
        .out_sel(os[1]), .dp_result(dp_res[1]), .busy(busy_v[1])
    );

    function automatic int lat_of(input int k);
        return (k == 0) ? 24 : 2;
    endfunction

    // Stand-in datapath function; only its low nibble matters as n1.
    function automatic logic [6:0] dp_fn(input logic [6:0] n2, input logic [6:0] t1, input logic [6:0] t2);
        int v;
        v = int'(n2[3:0]) * 3 + int'(t1) + int'(t2) * 2;
        return v[6:0];
    endfunction

    // Datapath stub: operand registers load on their strobes, output register on out_sel.
    logic [6:0] sn2 [2];
    logic [6:0] st1 [2];
    logic [6:0] st2 [2];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (n2s[k]) begin
                sn2[k]    <= dp_data[k];
                dp_res[k] <= 7'h5A;
            end
            if (t1s[k]) st1[k] <= dp_data[k];
            if (t2s[k]) st2[k] <= dp_data[k];
            if (os[k])  dp_res[k] <= dp_fn(sn2[k], st1[k], st2[k]);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: operand count, error flag and the edge of t2 acceptance.
    bit         m_act [2];
    int         m_got [2];
    bit         m_bad [2];
    int         m_t2e [2];
    logic [6:0] m_ops [2][3];
    logic [6:0] e_dp  [2];
    logic       e_n2  [2];
    logic       e_t1  [2];
    logic       e_t2  [2];
    logic       e_os  [2];
    logic       e_rv  [2];
    logic [3:0] e_rd  [2];
    logic       e_re  [2];
    bit         chk_en = 1'b0;
    int         edge_n = 0;

    task automatic model_step(input int k);
        int         lat;
        logic [6:0] v;
        lat = lat_of(k);
        e_n2[k] = 1'b0;
        e_t1[k] = 1'b0;
        e_t2[k] = 1'b0;
        e_os[k] = 1'b0;
        if (rst) begin
            m_act[k] = 1'b0;
            m_got[k] = 0;
            m_bad[k] = 1'b0;
            e_dp[k]  = '0;
            e_rv[k]  = 1'b0;
            e_rd[k]  = '0;
            e_re[k]  = 1'b0;
            return;
        end
        if (m_act[k] && m_got[k] == 3 && !m_bad[k] && edge_n == m_t2e[k] + lat)
            e_os[k] = 1'b1;
        if (m_act[k] && m_got[k] == 3 && !m_bad[k] && edge_n == m_t2e[k] + lat + 3) begin
            v       = dp_fn(m_ops[k][0], m_ops[k][1], m_ops[k][2]);
            e_rv[k] = 1'b1;
            e_rd[k] = v[3:0];
            e_re[k] = 1'b0;
        end else if (e_rv[k] && res_ready) begin
            e_rv[k]  = 1'b0;
            m_act[k] = 1'b0;
        end else if (!m_act[k] && start_v[k]) begin
            m_act[k] = 1'b1;
            m_got[k] = 0;
            m_bad[k] = 1'b0;
        end else if (m_act[k] && m_got[k] < 3 && in_valid) begin
            e_dp[k] = in_data;
            m_ops[k][m_got[k]] = in_data;
            case (m_got[k])
                0: begin
                    e_n2[k] = 1'b1;
                    if (in_data[3:0] == 4'd0) m_bad[k] = 1'b1;
                end
                1: begin
                    e_t1[k] = 1'b1;
                    if (in_data == 7'd0 || in_data > 7'd90) m_bad[k] = 1'b1;
                end
                default: begin
                    e_t2[k] = 1'b1;
                    if (in_data > 7'd90) m_bad[k] = 1'b1;
                end
            endcase
            m_got[k]++;
            if (m_got[k] == 3) begin
                m_t2e[k] = edge_n;
                if (m_bad[k]) begin
                    e_rv[k] = 1'b1;
                    e_rd[k] = '0;
                    e_re[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_cycle();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("busy[%0d]", k),     32'(busy_v[k]), 32'(m_act[k]));
            check($sformatf("in_ready[%0d]", k), 32'(rdy[k]),    32'(m_act[k] && m_got[k] < 3));
            check($sformatf("n2_sel[%0d]", k),   32'(n2s[k]),    32'(e_n2[k]));
            check($sformatf("t1_sel[%0d]", k),   32'(t1s[k]),    32'(e_t1[k]));
            check($sformatf("t2_sel[%0d]", k),   32'(t2s[k]),    32'(e_t2[k]));
            check($sformatf("out_sel[%0d]", k),  32'(os[k]),     32'(e_os[k]));
            check($sformatf("dp_data[%0d]", k),  32'(dp_data[k]), 32'(e_dp[k]));
            check($sformatf("res_valid[%0d]", k), 32'(rv[k]),    32'(e_rv[k]));
            check($sformatf("res_data[%0d]", k), 32'(rd[k]),     32'(e_rd[k]));
            check($sformatf("res_err[%0d]", k),  32'(re[k]),     32'(e_re[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input int idx, input logic [6:0] d);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!rdy[k] && n < 20) begin
            tick();
            n++;
        end
        check($sformatf("send_ready[%0d]", k), 32'(n < 20), 32'd1);
        tick();
        in_valid = 1'b0;
        case (idx)
            0:       check("n2_strobe", 32'(n2s[k]), 32'd1);
            1:       check("t1_strobe", 32'(t1s[k]), 32'd1);
            default: check("t2_strobe", 32'(t2s[k]), 32'd1);
        endcase
        check("strobe_data", 32'(dp_data[k]), 32'(d));
    endtask

    task automatic run_txn(input int k, input logic [6:0] n2, input logic [6:0] t1, input logic [6:0] t2,
                           input int gap, input int hold, input bit exp_err,
                           input logic [3:0] exp_rd, input int exp_lat);
        int n;
        start_v[k] = 1'b1;
        tick();
        start_v[k] = 1'b0;
        send(k, 0, n2);
        repeat (gap) tick();
        send(k, 1, t1);
        repeat (gap) tick();
        send(k, 2, t2);
        n = 0;
        while (!rv[k] && n < 400) begin
            tick();
            n++;
        end
        check("latency", n, exp_lat);
        check("res_valid", 32'(rv[k]), 32'd1);
        check("res_data", 32'(rd[k]), 32'(exp_rd));
        check("res_err", 32'(re[k]), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            start_v[k] = (i == hold / 2);
            tick();
        end
        start_v[k] = 1'b0;
        check("hold_busy", 32'(busy_v[k]), 32'd1);
        check("hold_data", 32'(rd[k]), 32'(exp_rd));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("release_busy", 32'(busy_v[k]), 32'd0);
        check("release_valid", 32'(rv[k]), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        res_ready  = 1'b0;
        fork
            forever begin
                @(negedge clk);
                if (chk_en) compare_cycle();
                for (int k = 0; k < 2; k++) model_step(k);
                if (rst) chk_en = 1'b1;
                edge_n++;
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                check("reset_busy", 32'(busy_v[0]), 32'd0);
                check("reset_dp_data", 32'(dp_data[0]), 32'd0);
                check("reset_res_data", 32'(rd[0]), 32'd0);
                check("reset_in_ready", 32'(rdy[0]), 32'd0);

                // Nominal, then backpressure with an ignored start, then operand gaps.
                run_txn(0, 7'h06, 7'd30, 7'd20, 0, 0,  1'b0, 4'h8, 27);
                run_txn(0, 7'h06, 7'd30, 7'd20, 0, 10, 1'b0, 4'h8, 27);
                run_txn(0, 7'h0B, 7'd45, 7'd60, 3, 0,  1'b0, 4'h6, 27);
                // In-range edge: both angles exactly 90.
                run_txn(0, 7'h01, 7'd90, 7'd90, 0, 0,  1'b0, 4'h1, 27);
                // Range errors: result reported right after t2 acceptance.
                run_txn(0, 7'h06, 7'd0,  7'd20, 0, 0,  1'b1, 4'h0, 0);
                run_txn(0, 7'h06, 7'd30, 7'd95, 0, 0,  1'b1, 4'h0, 0);
                run_txn(0, 7'h00, 7'd30, 7'd20, 0, 2,  1'b1, 4'h0, 0);

                // Reset during WAIT, then a full sequence.
                start_v[0] = 1'b1;
                tick();
                start_v[0] = 1'b0;
                send(0, 0, 7'h06);
                send(0, 1, 7'd30);
                send(0, 2, 7'd20);
                repeat (5) tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("midrst_busy", 32'(busy_v[0]), 32'd0);
                check("midrst_out_sel", 32'(os[0]), 32'd0);
                check("midrst_valid", 32'(rv[0]), 32'd0);
                run_txn(0, 7'h06, 7'd30, 7'd20, 0, 0, 1'b0, 4'h8, 27);

                // Minimum latency instance.
                run_txn(1, 7'h05, 7'd10, 7'd7,  0, 0, 1'b0, 4'h7, 5);
                run_txn(1, 7'h06, 7'd30, 7'd20, 1, 3, 1'b0, 4'h8, 5);

                repeat (3) tick();
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        join
    end

endmodule
